// File: rtl/vc_fifo_bank.sv
// ---------------------------------------------------------------------------
// vc_fifo_bank
// Bank of NUM_VC independent virtual-channel FIFOs sharing one write port and
// one read port. Each port names its channel every cycle. Every VC keeps its
// own pointers, occupancy count, threshold flags and sticky error bits.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   init              operational enable; 0 = requests ignored, FIFO state held
//   wr_enable/wr_vc   push request and target channel, data_in = push data
//   rd_enable/rd_vc   pop request and source channel
//   umbral_full       almost-full threshold (count >= DEPTH - umbral_full)
//   umbral_empty      almost-empty threshold (count <= umbral_empty)
//   clr_err           clears every sticky error bit
//   data_out          registered pop data, one cycle after the accepted pop
//   valid_out         data_out holds a popped entry this cycle
//   full, empty, almost_full, almost_empty   per-VC occupancy flags
//   overflow_err      sticky per VC: a push to a full VC was dropped
//   underflow_err     sticky per VC: a pop hit an empty VC
// ---------------------------------------------------------------------------
module vc_fifo_bank #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_VC     = 2,
    parameter int VC_W       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  wr_enable,
    input  logic [VC_W-1:0]       wr_vc,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [VC_W-1:0]       rd_vc,
    input  logic [ADDR_WIDTH-1:0] umbral_full,
    input  logic [ADDR_WIDTH-1:0] umbral_empty,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [NUM_VC-1:0]     full,
    output logic [NUM_VC-1:0]     empty,
    output logic [NUM_VC-1:0]     almost_full,
    output logic [NUM_VC-1:0]     almost_empty,
    output logic [NUM_VC-1:0]     overflow_err,
    output logic [NUM_VC-1:0]     underflow_err
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem    [NUM_VC][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr [NUM_VC];
    logic [ADDR_WIDTH-1:0] rd_ptr [NUM_VC];
    logic [ADDR_WIDTH:0]   count  [NUM_VC];

    logic wr_hit, rd_hit, pop_ok, push_ok, same_vc_pop, wr_is_full, rd_is_empty;
    logic [NUM_VC-1:0] push_sel, pop_sel, ovf_sel, udf_sel;

    // Request qualification. A full VC still accepts a push when the same
    // cycle pops that VC, since the freed slot is the one being written.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        push_sel    = '0;
        pop_sel     = '0;
        ovf_sel     = '0;
        udf_sel     = '0;
        wr_hit      = init && wr_enable && (int'(wr_vc) < NUM_VC);
        rd_hit      = init && rd_enable && (int'(rd_vc) < NUM_VC);
        rd_is_empty = rd_hit && (count[rd_vc] == '0);
        pop_ok      = rd_hit && (count[rd_vc] != '0);
        same_vc_pop = pop_ok && (rd_vc == wr_vc);
        wr_is_full  = wr_hit && (count[wr_vc] == DEPTH_CNT);
        push_ok     = wr_hit && (!wr_is_full || same_vc_pop);
        for (int v = 0; v < NUM_VC; v++) begin
            push_sel[v] = push_ok && (int'(wr_vc) == v);
            pop_sel[v]  = pop_ok && (int'(rd_vc) == v);
            ovf_sel[v]  = wr_is_full && !same_vc_pop && (int'(wr_vc) == v);
            udf_sel[v]  = rd_is_empty && (int'(rd_vc) == v);
        end
    end

    // Occupancy flags straight from the registered counts.
    always_comb begin
        full         = '0;
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]         = (count[v] == DEPTH_CNT);
            empty[v]        = (count[v] == '0);
            almost_full[v]  = (count[v] >= (DEPTH_CNT - {1'b0, umbral_full}));
            almost_empty[v] = (count[v] <= {1'b0, umbral_empty});
        end
    end

    // NOTE: storage has no reset; pointers and counts alone define which
    // entries are live, so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_vc][wr_ptr[wr_vc]] <= data_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            data_out      <= '0;
            valid_out     <= 1'b0;
            overflow_err  <= '0;
            underflow_err <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_sel[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop_sel[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                case ({push_sel[v], pop_sel[v]})
                    2'b10:   count[v] <= count[v] + 1'b1;
                    2'b01:   count[v] <= count[v] - 1'b1;
                    default: count[v] <= count[v];
                endcase
                // A new error event in the same cycle as clr_err wins.
                if (ovf_sel[v])                overflow_err[v] <= 1'b1;
                else if (init && clr_err)      overflow_err[v] <= 1'b0;
                if (udf_sel[v])                underflow_err[v] <= 1'b1;
                else if (init && clr_err)      underflow_err[v] <= 1'b0;
            end
            // valid_out is a one-cycle strobe per accepted pop; an empty pop
            // never forwards same-cycle write data.
            if (pop_ok) begin
                data_out  <= mem[rd_vc][rd_ptr[rd_vc]];
                valid_out <= 1'b1;
            end else begin
                data_out  <= '0;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// ---------------------------------------------------------------------------
// tb_vc_fifo_bank
// Directed and random stimulus for vc_fifo_bank. The reference model keeps one
// queue per VC; each accepted pop pushes the expected word and its due cycle
// onto a scoreboard, and a negedge monitor compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_vc_fifo_bank;

    localparam int DW    = 6;
    localparam int AW    = 4;
    localparam int NV    = 2;
    localparam int VW    = 1;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, init, wr_enable, rd_enable, clr_err;
    logic [VW-1:0] wr_vc, rd_vc;
    logic [DW-1:0] data_in, data_out;
    logic [AW-1:0] umbral_full, umbral_empty;
    logic          valid_out;
    logic [NV-1:0] full, empty, almost_full, almost_empty, overflow_err, underflow_err;

    vc_fifo_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV), .VC_W(VW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .wr_enable(wr_enable), .wr_vc(wr_vc), .data_in(data_in),
        .rd_enable(rd_enable), .rd_vc(rd_vc),
        .umbral_full(umbral_full), .umbral_empty(umbral_empty), .clr_err(clr_err),
        .data_out(data_out), .valid_out(valid_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mq[NV][$];
    logic [NV-1:0] m_ovf, m_udf;
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output cycle is either a popped word that the scoreboard
    // predicted for exactly this cycle, or an idle cycle with data_out = 0.
    always @(negedge clk) begin
        exp_t e;
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("valid_spurious", valid_out, 0);
            end else begin
                e = sb.pop_front();
                check("rd_data", data_out, e.data);
                check("rd_latency", cyc, e.cyc);
            end
        end else begin
            check("idle_data", data_out, 0);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                check("valid_missing", valid_out, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic model_clear();
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_ovf = '0;
        m_udf = '0;
        sb.delete();
    endtask

    task automatic check_flags();
        for (int v = 0; v < NV; v++) begin
            int n;
            n = mq[v].size();
            check($sformatf("full[%0d]", v), full[v], n == DEPTH);
            check($sformatf("empty[%0d]", v), empty[v], n == 0);
            check($sformatf("almost_full[%0d]", v), almost_full[v], n >= DEPTH - int'(umbral_full));
            check($sformatf("almost_empty[%0d]", v), almost_empty[v], n <= int'(umbral_empty));
            check($sformatf("overflow_err[%0d]", v), overflow_err[v], m_ovf[v]);
            check($sformatf("underflow_err[%0d]", v), underflow_err[v], m_udf[v]);
            check($sformatf("count[%0d]", v), dut.count[v], n);
            total++;
            assert (dut.count[v] <= DEPTH)
            else begin
                bad++;
                $display("FAIL count_range[%0d]: got %0d limit %0d", v, dut.count[v], DEPTH);
            end
        end
    endtask

    // One clock of stimulus. The model applies the queue semantics: a pop
    // takes the head (so a full VC can take a same-cycle push), an empty pop
    // flags underflow, a push to a full VC without a same-VC pop is dropped.
    task automatic step(input bit i, input bit we, input logic [VW-1:0] wv, input logic [DW-1:0] d,
                        input bit re, input logic [VW-1:0] rv, input bit ce);
        bit   wok, rok, pop_ok, same, full_w, push_ok;
        exp_t e;
        init = i; wr_enable = we; wr_vc = wv; data_in = d;
        rd_enable = re; rd_vc = rv; clr_err = ce;
        wok     = int'(wv) < NV;
        rok     = int'(rv) < NV;
        pop_ok  = i && re && rok && (mq[rv].size() > 0);
        same    = pop_ok && (rv == wv);
        full_w  = wok && (mq[wv].size() == DEPTH);
        push_ok = i && we && wok && (!full_w || same);
        if (i && ce) begin
            m_ovf = '0;
            m_udf = '0;
        end
        if (i && we && wok && full_w && !same) m_ovf[wv] = 1'b1;
        if (i && re && rok && mq[rv].size() == 0) m_udf[rv] = 1'b1;
        if (pop_ok) begin
            e.data = mq[rv].pop_front();
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        if (push_ok) mq[wv].push_back(d);
        @(posedge clk);
        #1;
        check_flags();
    endtask

    task automatic push(input logic [VW-1:0] vc, input logic [DW-1:0] d);
        step(1, 1, vc, d, 0, 0, 0);
    endtask

    task automatic pop(input logic [VW-1:0] vc);
        step(1, 0, 0, 0, 1, vc, 0);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0; clr_err = 1'b0;
        wr_vc = '0; rd_vc = '0; data_in = '0;
        umbral_full = 4'd2; umbral_empty = 4'd3;
        model_clear();
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle after reset.
        idle();
        check("idle_empty", empty, 2'b11);
        check("idle_full", full, 2'b00);
        check("idle_almost_empty", almost_empty, 2'b11);
        check("idle_valid", valid_out, 0);

        // Fill VC1, overflow it, drain it in order.
        for (int k = 1; k <= 16; k++) begin
            push(1, DW'(k));
            if (k == 13) check("af_after13", almost_full[1], 0);
            if (k == 14) check("af_after14", almost_full[1], 1);
            if (k == 15) check("full_after15", full[1], 0);
            if (k == 16) check("full_after16", full[1], 1);
        end
        check("vc0_still_empty", empty[0], 1);
        push(1, 6'h11);
        check("ovf_on_17th", overflow_err[1], 1);
        for (int k = 0; k < 16; k++) pop(1);
        idle();
        check("vc1_drained", empty[1], 1);

        // Interleaved channels.
        push(0, 6'h0A); push(1, 6'h0B); push(0, 6'h0A); push(1, 6'h0B);
        pop(1); pop(0); pop(1); pop(0);
        idle();

        // Full VC0 with simultaneous push/pop, then drain across the wrap.
        for (int k = 0; k < 16; k++) push(0, DW'($urandom));
        step(1, 1, 0, 6'h3F, 1, 0, 0);
        check("wrap_count", dut.count[0], 16);
        check("wrap_no_ovf", overflow_err[0], 0);
        for (int k = 0; k < 16; k++) pop(0);
        idle();

        // Empty pop on VC0 with same-cycle push: no bypass.
        step(1, 1, 0, 6'h05, 1, 0, 0);
        check("udf_set", underflow_err[0], 1);
        check("udf_no_valid", valid_out, 0);
        check("udf_count", dut.count[0], 1);
        pop(0);
        step(1, 0, 0, 0, 0, 0, 1);
        check("udf_cleared", underflow_err[0], 0);

        // Random traffic with varying thresholds (including zero).
        for (int n = 0; n < 600; n++) begin
            bit i, we, re, ce;
            if (n % 50 == 0) begin
                umbral_full  = AW'($urandom_range(0, 15));
                umbral_empty = AW'($urandom_range(0, 15));
            end
            i  = $urandom_range(0, 9) != 0;
            we = ((n / 80) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            re = ((n / 80) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ce = i && ($urandom_range(0, 30) == 0);
            step(i, we, VW'($urandom_range(0, NV - 1)), DW'($urandom), re,
                 VW'($urandom_range(0, NV - 1)), ce);
        end
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < DEPTH && mq[v].size() > 0; k++) pop(VW'(v));
        end
        idle();
        umbral_full = 4'd2; umbral_empty = 4'd3;

        // Asynchronous reset mid-burst with 7 entries left in VC1.
        for (int k = 0; k < 8; k++) push(1, DW'(8'h20 + k));
        pop(0);
        check("pre_rst_udf", underflow_err[0], 1);
        pop(1);
        check("pre_rst_valid", valid_out, 1);
        check("pre_rst_data", data_out, 6'h20);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check("arst_valid", valid_out, 0);
        check("arst_data", data_out, 0);
        check("arst_empty", empty, 2'b11);
        check("arst_full", full, 2'b00);
        check("arst_ovf", overflow_err, 0);
        check("arst_udf", underflow_err, 0);
        rd_enable = 1'b0; wr_enable = 1'b0; init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_flags();
        pop(1);
        check("post_rst_empty", empty[1], 1);
        check("post_rst_udf", underflow_err[1], 1);
        idle();
        idle();
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
